// File: rtl/lcd_bcd_feeder_pkg.sv
// Shared definitions for the LCD BCD feeder.
// FSM states, byte/digit counts and nibble helpers.
package lcd_bcd_feeder_pkg;

    localparam int LCD_BYTES  = 6;
    localparam int BCD_DIGITS = 10;
    localparam int BCD_BITS   = BCD_DIGITS * 4;
    localparam int LINE_BITS  = LCD_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV0  = 2'd1,
        ST_CONV1  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Double-dabble digit correction: a nibble of 5..9 would
    // carry past 9 after the next shift, so bias it by 3 first.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Place a 10-digit BCD value into a 6-byte display line.
    function automatic logic [LINE_BITS-1:0] bcd_to_line(
        input logic [BCD_BITS-1:0] b
    );
        return {{(LINE_BITS - BCD_BITS){1'b0}}, b};
    endfunction

endpackage

// File: rtl/lcd_bcd_feeder_bin2bcd_step.sv
// One double-dabble iteration: add-3 correction then shift.
// Purely combinational; time-shared by the feeder FSM.
module bin2bcd_step
    import lcd_bcd_feeder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [BCD_BITS-1:0] bcd,
    input  logic [WIDTH-1:0]    bin,
    output logic [BCD_BITS-1:0] bcd_next,
    output logic [WIDTH-1:0]    bin_next
);

    logic [BCD_BITS-1:0] adj;

    // Correct every digit before the shift.
    always_comb begin
        adj = '0;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            adj[4*d +: 4] = add3(bcd[4*d +: 4]);
        end
    end

    // Binary MSB shifts into the BCD LSB; the BCD MSB is
    // always zero for legal widths, so it is dropped.
    assign bcd_next = BCD_BITS'({adj, bin[WIDTH-1]});
    assign bin_next = {bin[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/lcd_bcd_feeder.sv
// Two-line binary to packed-BCD feeder for the LCD driver.
// One bit per clock, line 0 then line 1, double-buffered.
module lcd_bcd_feeder
    import lcd_bcd_feeder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSTART,
    input  logic             iHEX,
    input  logic [WIDTH-1:0] iVAL0,
    input  logic [WIDTH-1:0] iVAL1,
    output logic             oBUSY,
    output logic             oDONE,
    output logic [7:0]       d0x0,
    output logic [7:0]       d0x1,
    output logic [7:0]       d0x2,
    output logic [7:0]       d0x3,
    output logic [7:0]       d0x4,
    output logic [7:0]       d0x5,
    output logic [7:0]       d1x0,
    output logic [7:0]       d1x1,
    output logic [7:0]       d1x2,
    output logic [7:0]       d1x3,
    output logic [7:0]       d1x4,
    output logic [7:0]       d1x5
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PAD_W = LINE_BITS - WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     val0_q;
    logic [WIDTH-1:0]     val1_q;
    logic                 hex_q;
    logic [BCD_BITS-1:0]  bcd_q;
    logic [WIDTH-1:0]     bin_q;
    logic [LINE_BITS-1:0] stage0_q;
    logic [LINE_BITS-1:0] stage1_q;
    logic [LINE_BITS-1:0] out0_q;
    logic [LINE_BITS-1:0] out1_q;
    logic                 done_q;

    logic [BCD_BITS-1:0]  step_bcd;
    logic [WIDTH-1:0]     step_bin;
    logic                 last_bit;
    logic [LINE_BITS-1:0] line0_res;
    logic [LINE_BITS-1:0] line1_res;

    bin2bcd_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .bcd      (bcd_q),
        .bin      (bin_q),
        .bcd_next (step_bcd),
        .bin_next (step_bin)
    );

    assign last_bit = (cnt_q == LAST);

    // Final-step result per line: raw hex or the converted BCD.
    assign line0_res = hex_q ? {{PAD_W{1'b0}}, val0_q}
                             : bcd_to_line(step_bcd);
    assign line1_res = hex_q ? {{PAD_W{1'b0}}, val1_q}
                             : bcd_to_line(step_bcd);

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only from IDLE, one bit per edge per line.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (iSTART)   state_d = ST_CONV0;
            ST_CONV0:  if (last_bit) state_d = ST_CONV1;
            ST_CONV1:  if (last_bit) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Operand capture, shift datapath and line staging.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q    <= '0;
            val0_q   <= '0;
            val1_q   <= '0;
            hex_q    <= 1'b0;
            bcd_q    <= '0;
            bin_q    <= '0;
            stage0_q <= '0;
            stage1_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (iSTART) begin
                        val0_q <= iVAL0;
                        val1_q <= iVAL1;
                        hex_q  <= iHEX;
                        bcd_q  <= '0;
                        bin_q  <= iVAL0;
                        cnt_q  <= '0;
                    end
                end
                ST_CONV0: begin
                    if (last_bit) begin
                        stage0_q <= line0_res;
                        bcd_q    <= '0;
                        bin_q    <= val1_q;
                        cnt_q    <= '0;
                    end else begin
                        bcd_q <= step_bcd;
                        bin_q <= step_bin;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CONV1: begin
                    if (last_bit) begin
                        stage1_q <= line1_res;
                        cnt_q    <= '0;
                    end else begin
                        bcd_q <= step_bcd;
                        bin_q <= step_bin;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    cnt_q <= '0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // Display registers change only on the commit edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            out0_q <= '0;
            out1_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_COMMIT) begin
                out0_q <= stage0_q;
                out1_q <= stage1_q;
                done_q <= 1'b1;
            end
        end
    end

    assign oBUSY = (state_q != ST_IDLE);
    assign oDONE = done_q;

    assign d0x0 = out0_q[7:0];
    assign d0x1 = out0_q[15:8];
    assign d0x2 = out0_q[23:16];
    assign d0x3 = out0_q[31:24];
    assign d0x4 = out0_q[39:32];
    assign d0x5 = out0_q[47:40];
    assign d1x0 = out1_q[7:0];
    assign d1x1 = out1_q[15:8];
    assign d1x2 = out1_q[23:16];
    assign d1x3 = out1_q[31:24];
    assign d1x4 = out1_q[39:32];
    assign d1x5 = out1_q[47:40];

endmodule

// File: tb/tb_lcd_bcd_feeder.sv
// Bench for lcd_bcd_feeder: WIDTH=16 and WIDTH=32 instances
// against a decimal-arithmetic model plus literal checks.
module tb_lcd_bcd_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  start_v = '0;
    logic [1:0]  hex_v = '0;
    logic [31:0] in_v0 [2];
    logic [31:0] in_v1 [2];
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [47:0] g0 [2];
    logic [47:0] g1 [2];

    int n_tests = 0;
    int n_fail = 0;

    logic [7:0] a00, a01, a02, a03, a04, a05;
    logic [7:0] a10, a11, a12, a13, a14, a15;
    logic [7:0] b00, b01, b02, b03, b04, b05;
    logic [7:0] b10, b11, b12, b13, b14, b15;

    lcd_bcd_feeder #(.WIDTH(16)) u_dut16 (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start_v[0]),
        .iHEX(hex_v[0]), .iVAL0(in_v0[0][15:0]),
        .iVAL1(in_v1[0][15:0]),
        .oBUSY(busy_v[0]), .oDONE(done_v[0]),
        .d0x0(a00), .d0x1(a01), .d0x2(a02),
        .d0x3(a03), .d0x4(a04), .d0x5(a05),
        .d1x0(a10), .d1x1(a11), .d1x2(a12),
        .d1x3(a13), .d1x4(a14), .d1x5(a15)
    );

    lcd_bcd_feeder #(.WIDTH(32)) u_dut32 (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start_v[1]),
        .iHEX(hex_v[1]), .iVAL0(in_v0[1]), .iVAL1(in_v1[1]),
        .oBUSY(busy_v[1]), .oDONE(done_v[1]),
        .d0x0(b00), .d0x1(b01), .d0x2(b02),
        .d0x3(b03), .d0x4(b04), .d0x5(b05),
        .d1x0(b10), .d1x1(b11), .d1x2(b12),
        .d1x3(b13), .d1x4(b14), .d1x5(b15)
    );

    assign g0[0] = {a05, a04, a03, a02, a01, a00};
    assign g1[0] = {a15, a14, a13, a12, a11, a10};
    assign g0[1] = {b05, b04, b03, b02, b01, b00};
    assign g1[1] = {b15, b14, b13, b12, b11, b10};

    // Expected display line: decimal digits or raw hex bytes.
    function automatic logic [47:0] line_of(input logic [31:0] v,
                                            input logic hex);
        logic [47:0] r;
        longint unsigned x;
        r = '0;
        if (hex) return {16'h0, v};
        x = longint'(v);
        for (int d = 0; d < 12; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Transaction-level model: cycles-to-commit per instance.
    int          rem [2];
    logic [47:0] p0 [2];
    logic [47:0] p1 [2];
    logic [47:0] m0 [2];
    logic [47:0] m1 [2];
    logic [1:0]  m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rem[i] <= 0;
                m0[i] <= '0;
                m1[i] <= '0;
                p0[i] <= '0;
                p1[i] <= '0;
            end
            m_done <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i] <= 1'b0;
                if (rem[i] == 0) begin
                    if (start_v[i]) begin
                        rem[i] <= 2 * (i == 0 ? 16 : 32) + 1;
                        p0[i] <= line_of(i == 0 ? {16'h0, in_v0[i][15:0]}
                                                : in_v0[i], hex_v[i]);
                        p1[i] <= line_of(i == 0 ? {16'h0, in_v1[i][15:0]}
                                                : in_v1[i], hex_v[i]);
                    end
                end else begin
                    rem[i] <= rem[i] - 1;
                    if (rem[i] == 1) begin
                        m0[i] <= p0[i];
                        m1[i] <= p1[i];
                        m_done[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (g0[i] !== m0[i] || g1[i] !== m1[i] ||
                busy_v[i] !== (rem[i] != 0) ||
                done_v[i] !== m_done[i]) begin
                n_fail++;
                $display("FAIL model dut%0d t=%0t l0 %h want %h l1 %h want %h busy %b want %b done %b want %b",
                         i, $time, g0[i], m0[i], g1[i], m1[i],
                         busy_v[i], (rem[i] != 0), done_v[i], m_done[i]);
            end
        end
    end

    task automatic chk(input string nm, input logic [47:0] got,
                       input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic kick(input int i, input logic [31:0] v0,
                        input logic [31:0] v1, input logic h);
        in_v0[i] = v0;
        in_v1[i] = v1;
        hex_v[i] = h;
        start_v[i] = 1'b1;
        @(posedge clk);
        #2;
        start_v[i] = 1'b0;
    endtask

    // Edges from acceptance to the first oDONE, bounded.
    task automatic run(input int i, input logic [31:0] v0,
                       input logic [31:0] v1, input logic h,
                       output int lat);
        in_v0[i] = v0;
        in_v1[i] = v1;
        hex_v[i] = h;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done_v[i]) begin
                lat = n;
                break;
            end
        end
        #1;
    endtask

    task automatic count_done(input int i, input int cyc,
                              output int cnt);
        cnt = 0;
        for (int n = 0; n < cyc; n++) begin
            @(posedge clk);
            #1;
            if (done_v[i]) cnt++;
        end
        #1;
    endtask

    initial begin
        int lat;
        int cnt;
        for (int i = 0; i < 2; i++) begin
            in_v0[i] = '0;
            in_v1[i] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("reset_l0", g0[0], 48'h0);
        chk("reset_busy_done", {46'h0, busy_v[0], done_v[0]}, 48'h0);

        run(0, 32'd12345, 32'd0, 1'b0, lat);
        chk("t1_latency", 48'(lat), 48'd33);
        chk("t1_l0", g0[0], 48'h000000012345);
        chk("t1_l1", g1[0], 48'h0);

        kick(0, 32'd65535, 32'd9, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        chk("t2_hold", g0[0], 48'h000000012345);
        count_done(0, 20, cnt);
        chk("t2_l0", g0[0], 48'h000000065535);
        chk("t2_l1", g1[0], 48'h000000000009);

        run(0, 32'hBEEF, 32'h1234, 1'b1, lat);
        chk("t3_latency", 48'(lat), 48'd33);
        chk("t3_l0", g0[0], 48'h00000000BEEF);
        chk("t3_l1", g1[0], 48'h000000001234);

        kick(0, 32'd4321, 32'd8765, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        in_v0[0] = 32'd1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #2;
        start_v[0] = 1'b0;
        count_done(0, 40, cnt);
        chk("t4_single_done", 48'(cnt), 48'd1);
        chk("t4_l0", g0[0], 48'h000000004321);
        chk("t4_l1", g1[0], 48'h000000008765);
        run(0, 32'd1, 32'd2, 1'b0, lat);
        chk("t4_next_l0", g0[0], 48'h000000000001);
        chk("t4_next_l1", g1[0], 48'h000000000002);

        kick(0, 32'd777, 32'd42, 1'b0);
        repeat (18) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_l0", g0[0], 48'h0);
        chk("t5_rst_l1", g1[0], 48'h0);
        chk("t5_rst_busy", {47'h0, busy_v[0]}, 48'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        count_done(0, 40, cnt);
        chk("t5_no_done", 48'(cnt), 48'd0);
        run(0, 32'd777, 32'd42, 1'b0, lat);
        chk("t5_fresh_latency", 48'(lat), 48'd33);
        chk("t5_fresh_l0", g0[0], 48'h000000000777);
        chk("t5_fresh_l1", g1[0], 48'h000000000042);

        run(1, 32'hFFFFFFFF, 32'd100, 1'b0, lat);
        chk("t6_latency", 48'(lat), 48'd65);
        chk("t6_l0", g0[1], 48'h004294967295);
        chk("t6_l1", g1[1], 48'h000000000100);

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
